lcg_stream_checker: RTL

Receive-side checker for the 32-bit linear-congruential stimulus stream used across the fuzzing benches (x' = x·0x41C64E6D + 0x3039 mod 2^32). It self-synchronises to an incoming word stream, regenerates the expected sequence, and reports lock status, per-beat mismatches and saturating match/error counters. It sits at the output side of a DUT or loopback path, where stimulus words are returned to the bench, and closes the loop without a software comparison.

---
 rtl/lcg_stream_checker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lcg_stream_checker.sv
`default_nettype none
// ============================================================================
// lcg_stream_checker
//   Self-synchronising checker for the 32-bit LCG stimulus stream
//   (x' = x*0x41C64E6D + 0x3039): lock tracking, mismatch pulses, counters.
// Revision: 1.0
// ============================================================================
module lcg_stream_checker #(
  parameter int LOCK_COUNT  = 4,
  parameter int UNLOCK_ERRS = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [31:0]      expected,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int          RUN_W     = $clog2(LOCK_COUNT + 1);
  localparam int          CON_W     = $clog2(UNLOCK_ERRS + 1);
  localparam logic [31:0] C_LCG_MUL = 32'h41C64E6D;
  localparam logic [31:0] C_LCG_INC = 32'h0000_3039;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_SYNC = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [CON_W-1:0] consec_q, consec_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [31:0]      expected_q, expected_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [31:0]      w_next;
  logic             w_hit;

  assign w_next = prev_q * C_LCG_MUL + C_LCG_INC;
  assign w_hit  = (in_data == w_next);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    run_d       = run_q;
    consec_d    = consec_q;
    expected_d  = expected_q;
    err_pulse_d = 1'b0;
    match_cnt_d = match_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (in_valid) begin
      case (state_q)
        S_HUNT: begin
          prev_d  = in_data;
          run_d   = '0;
          state_d = S_SYNC;
        end
        S_SYNC: begin
          prev_d = in_data;
          if (w_hit) begin
            run_d = run_q + RUN_W'(1);
            if (run_q + RUN_W'(1) == RUN_W'(LOCK_COUNT)) begin
              state_d  = S_LOCK;
              consec_d = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        S_LOCK: begin
          // Flywheel on the prediction so a corrupted word cannot derail it.
          prev_d     = w_next;
          expected_d = w_next;
          if (w_hit) begin
            consec_d = '0;
            if (match_cnt_q != {CNT_W{1'b1}}) match_cnt_d = match_cnt_q + CNT_W'(1);
          end else begin
            err_pulse_d = 1'b1;
            consec_d    = consec_q + CON_W'(1);
            if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
            if (consec_q + CON_W'(1) == CON_W'(UNLOCK_ERRS)) state_d = S_HUNT;
          end
        end
        default: state_d = S_HUNT;
      endcase
    end

    if (clear_cnt) begin
      match_cnt_d = '0;
      err_cnt_d   = '0;
    end

    locked_d = (state_d == S_LOCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HUNT;
      prev_q      <= '0;
      run_q       <= '0;
      consec_q    <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      expected_q  <= '0;
      match_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      consec_q    <= consec_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign expected  = expected_q;
  assign match_cnt = match_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire
